// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit display scan controller.
// Digit 0 sits in the low nibble of every display value.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] slot_t;

  typedef logic [NUM_DIGITS-1:0][3:0] disp_val_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SHOW,
    ACK
  } arb_state_t;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input slot_t s);
    logic [NUM_DIGITS-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

  // Digit i may light if any digit at or above i is nonzero; digit 0 always lights.
  function automatic logic [NUM_DIGITS-1:0] lz_enable(input disp_val_t v);
    logic [NUM_DIGITS-1:0] en;
    logic                  seen;
    en   = '0;
    seen = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      seen  = seen | (v[i] != 4'h0);
      en[i] = seen;
    end
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Source B request/acknowledge handshake: the requester drives req/data,
// the scan controller answers with busy/ack.
interface disp_scan_ctrl_if;

  logic                b_req;
  disp_pkg::disp_val_t b_data;
  logic                b_busy;
  logic                b_ack;

  modport master (
    output b_req,
    output b_data,
    input  b_busy,
    input  b_ack
  );

  modport slave (
    input  b_req,
    input  b_data,
    output b_busy,
    output b_ack
  );

endinterface

// File: rtl/scan_prescaler.sv
// Digit-slot timebase: prescaler 0..DIV-1, slot 0..NUM_DIGITS-1, frame boundary
// strobe on the last cycle of the last slot, and a blanking flag for early slot cycles.
module scan_prescaler
  import disp_pkg::*;
#(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 2000
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  output slot_t slot_o,
  output logic  fb_o,
  output logic  blank_o
);

  localparam int unsigned     CntW     = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK);
  localparam slot_t           SlotMax  = slot_t'(NUM_DIGITS - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  slot_t           slot_q, slot_d;
  logic            wrap;

  assign wrap = (cnt_q == CntMax);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
    slot_d = slot_q;
    if (wrap) begin
      slot_d = (slot_q == SlotMax) ? '0 : slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign slot_o  = slot_q;
  assign fb_o    = wrap && (slot_q == SlotMax);
  assign blank_o = (cnt_q < BlankEnd);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Display scan controller with a background source A and a borrowing source B.
// Value, mask and lz_en are latched at frame boundaries so a frame never tears.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIV         = 100000,
  parameter int unsigned BLANK       = 2000,
  parameter int unsigned HOLD_FRAMES = 500
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  disp_val_t             a_data,
  input  logic [NUM_DIGITS-1:0] a_mask,
  input  logic                  lz_en,
  disp_scan_ctrl_if.slave       b_if,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [3:0]            hex,
  output logic                  src,
  output logic                  frame_tick
);

  localparam int unsigned    FcW    = $clog2(HOLD_FRAMES + 1);
  localparam logic [FcW-1:0] FcLast = FcW'(HOLD_FRAMES - 1);

  slot_t slot;
  logic  fb;
  logic  blank;

  scan_prescaler #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_prescaler (
    .clk_i   (CLK100MHZ),
    .rst_ni  (reset),
    .slot_o  (slot),
    .fb_o    (fb),
    .blank_o (blank)
  );

  // Arbiter state
  arb_state_t      state_q, state_d;
  logic [FcW-1:0]  fcnt_q, fcnt_d;
  disp_val_t       b_buf_q, b_buf_d;
  logic            busy_q, busy_d;
  logic            sel_b;

  // Per-frame latched view
  disp_val_t             val_q, val_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                  lz_q, lz_d;
  logic                  src_q, src_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            hex_q, hex_d;
  logic                  tick_q;
  logic                  ack_q;

  // sel_b picks the source of the frame latched at this cycle's boundary.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    b_buf_d = b_buf_q;
    busy_d  = busy_q;
    sel_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (b_if.b_req) begin
          b_buf_d = b_if.b_data;
          busy_d  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (fb) begin
          sel_b   = 1'b1;
          fcnt_d  = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (fb) begin
          fcnt_d = fcnt_q + FcW'(1);
          if (fcnt_q == FcLast) begin
            state_d = ACK;
          end else begin
            sel_b = 1'b1;
          end
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    val_d  = val_q;
    mask_d = mask_q;
    lz_d   = lz_q;
    src_d  = src_q;
    if (fb) begin
      val_d  = sel_b ? b_buf_q : a_data;
      mask_d = sel_b ? '1 : a_mask;
      lz_d   = lz_en;
      src_d  = sel_b;
    end
  end

  always_comb begin
    logic [NUM_DIGITS-1:0] lz_mask;
    lz_mask = lz_q ? lz_enable(val_q) : '1;
    an_d    = blank ? '0 : (digit_onehot(slot) & mask_q & lz_mask);
    hex_d   = val_q[slot];
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      b_buf_q <= '0;
      busy_q  <= 1'b0;
      val_q   <= '0;
      mask_q  <= '0;
      lz_q    <= 1'b0;
      src_q   <= 1'b0;
      an_q    <= '0;
      hex_q   <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      b_buf_q <= b_buf_d;
      busy_q  <= busy_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      lz_q    <= lz_d;
      src_q   <= src_d;
      an_q    <= an_d;
      hex_q   <= hex_d;
      tick_q  <= fb;
      ack_q   <= (state_q == ACK);
    end
  end

  assign AN          = an_q;
  assign hex         = hex_q;
  assign src         = src_q;
  assign frame_tick  = tick_q;
  assign b_if.b_busy = busy_q;
  assign b_if.b_ack  = ack_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV=8, BLANK=2, HOLD_FRAMES=3 (32-cycle frames).
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int Div   = 8;
  localparam int Blank = 2;
  localparam int Hold  = 3;

  logic      clk;
  logic      rst_n;
  disp_val_t a_data;
  logic [3:0] a_mask;
  logic      lz_en;
  logic [3:0] AN;
  logic [3:0] hex;
  logic      src;
  logic      frame_tick;

  disp_scan_ctrl_if b_if ();

  disp_scan_ctrl #(
    .DIV         (Div),
    .BLANK       (Blank),
    .HOLD_FRAMES (Hold)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (rst_n),
    .a_data     (a_data),
    .a_mask     (a_mask),
    .lz_en      (lz_en),
    .b_if       (b_if),
    .AN         (AN),
    .hex        (hex),
    .src        (src),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;

  // Per-frame stimulus events, consumed and cleared by check_frame.
  int          chg_at = -1;
  logic [15:0] nd;
  logic [3:0]  nm;
  logic        nl;
  int          req_at = -1;
  logic [15:0] rd;
  logic        pre_busy;
  logic        drop_req;
  int          ack_at = -1;
  logic        rebusy;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // After reset: 32 samples with everything dark, tick on the last.
  task automatic dark_frame();
    frame_no++;
    for (int s = 1; s <= 32; s++) begin
      @(negedge clk);
      check($sformatf("f%0d.%0d dark AN", frame_no, s), 16'(AN), 16'h0);
      check($sformatf("f%0d.%0d dark hex", frame_no, s), 16'(hex), 16'h0);
      check($sformatf("f%0d.%0d dark src", frame_no, s), 16'(src), 16'h0);
      check($sformatf("f%0d.%0d dark ack", frame_no, s), 16'(b_if.b_ack), 16'h0);
      check($sformatf("f%0d.%0d dark busy", frame_no, s), 16'(b_if.b_busy), 16'h0);
      check($sformatf("f%0d.%0d dark tick", frame_no, s), 16'(frame_tick), 16'(s == 32));
    end
  endtask

  // Checks one 32-sample frame; sample j shows outputs of frame cycle j.
  task automatic check_frame(input logic [15:0] ev, input logic [3:0] een, input logic es);
    int         sl;
    int         cn;
    logic [3:0] exp_an;
    logic [3:0] exp_hex;
    frame_no++;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      sl      = j / Div;
      cn      = j % Div;
      exp_an  = (cn < Blank) ? 4'b0000 : ((4'b0001 << sl) & een);
      exp_hex = 4'(ev >> (4 * sl));
      check($sformatf("f%0d.%0d AN", frame_no, j), 16'(AN), 16'(exp_an));
      check($sformatf("f%0d.%0d hex", frame_no, j), 16'(hex), 16'(exp_hex));
      check($sformatf("f%0d.%0d tick", frame_no, j), 16'(frame_tick), 16'(j == 31));
      check($sformatf("f%0d.%0d ack", frame_no, j), 16'(b_if.b_ack), 16'(j == ack_at));
      if (j < 31) check($sformatf("f%0d.%0d src", frame_no, j), 16'(src), 16'(es));
      if (j == chg_at) begin
        a_data = nd;
        a_mask = nm;
        lz_en  = nl;
      end
      if (j == req_at) begin
        check($sformatf("f%0d.%0d busy pre", frame_no, j), 16'(b_if.b_busy), 16'(pre_busy));
        b_if.b_req  = 1'b1;
        b_if.b_data = rd;
      end
      if (req_at >= 0 && j == req_at + 1) begin
        check($sformatf("f%0d.%0d busy post", frame_no, j), 16'(b_if.b_busy), 16'h1);
        if (drop_req) b_if.b_req = 1'b0;
      end
      if (ack_at >= 0 && j == ack_at) begin
        check($sformatf("f%0d.%0d busy at ack", frame_no, j), 16'(b_if.b_busy), 16'h0);
      end
      if (ack_at >= 0 && j == ack_at + 1) begin
        check($sformatf("f%0d.%0d busy re", frame_no, j), 16'(b_if.b_busy), 16'(rebusy));
        b_if.b_req = 1'b0;
      end
    end
    chg_at = -1;
    req_at = -1;
    ack_at = -1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_data      = 16'h1234;
    a_mask      = 4'hF;
    lz_en       = 1'b0;
    b_if.b_req  = 1'b0;
    b_if.b_data = 16'h0000;

    @(negedge clk);
    check("reset AN", 16'(AN), 16'h0);
    check("reset hex", 16'(hex), 16'h0);
    check("reset src", 16'(src), 16'h0);
    check("reset tick", 16'(frame_tick), 16'h0);
    check("reset ack", 16'(b_if.b_ack), 16'h0);
    check("reset busy", 16'(b_if.b_busy), 16'h0);
    rst_n = 1'b1;

    dark_frame();

    // Basic scan
    check_frame(16'h1234, 4'hF, 1'b0);

    // Tear-free update at slot 1
    chg_at = 12; nd = 16'h5678; nm = 4'hF; nl = 1'b0;
    check_frame(16'h1234, 4'hF, 1'b0);

    // Leading-zero suppression and mask
    chg_at = 20; nd = 16'h0050; nm = 4'hF; nl = 1'b1;
    check_frame(16'h5678, 4'hF, 1'b0);
    chg_at = 20; nd = 16'h0000; nm = 4'hF; nl = 1'b1;
    check_frame(16'h0050, 4'b0011, 1'b0);
    chg_at = 20; nd = 16'h1234; nm = 4'b1010; nl = 1'b0;
    check_frame(16'h0000, 4'b0001, 1'b0);
    chg_at = 20; nd = 16'h1234; nm = 4'hF; nl = 1'b0;
    check_frame(16'h1234, 4'b1010, 1'b0);

    // Source B grant, with an ignored request during SHOW
    req_at = 10; rd = 16'hBEEF; pre_busy = 1'b0; drop_req = 1'b1;
    check_frame(16'h1234, 4'hF, 1'b0);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    req_at = 10; rd = 16'hAAAA; pre_busy = 1'b1; drop_req = 1'b1;
    check_frame(16'hBEEF, 4'hF, 1'b1);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    ack_at = 0; rebusy = 1'b0;
    check_frame(16'h1234, 4'hF, 1'b0);

    // Reset during SHOW aborts the transaction
    req_at = 10; rd = 16'h1357; pre_busy = 1'b0; drop_req = 1'b1;
    check_frame(16'h1234, 4'hF, 1'b0);
    check_frame(16'h1357, 4'hF, 1'b1);
    repeat (13) @(negedge clk);
    check("abort pre src", 16'(src), 16'h1);
    rst_n = 1'b0;
    #1;
    check("abort AN", 16'(AN), 16'h0);
    check("abort hex", 16'(hex), 16'h0);
    check("abort src", 16'(src), 16'h0);
    check("abort tick", 16'(frame_tick), 16'h0);
    check("abort ack", 16'(b_if.b_ack), 16'h0);
    check("abort busy", 16'(b_if.b_busy), 16'h0);
    repeat (2) @(negedge clk);
    check("abort held ack", 16'(b_if.b_ack), 16'h0);
    rst_n = 1'b1;
    dark_frame();
    check_frame(16'h1234, 4'hF, 1'b0);
    check("post abort busy", 16'(b_if.b_busy), 16'h0);

    // Back-to-back requests with b_req held high
    req_at = 10; rd = 16'hBEEF; pre_busy = 1'b0; drop_req = 1'b0;
    check_frame(16'h1234, 4'hF, 1'b0);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    ack_at = 0; rebusy = 1'b1;
    check_frame(16'h1234, 4'hF, 1'b0);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    check_frame(16'hBEEF, 4'hF, 1'b1);
    ack_at = 0; rebusy = 1'b0;
    check_frame(16'h1234, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
